mem_access_sequencer: RTL
=========================

# mem_access_sequencer

Multi-cycle sequencer for the shared memory port between instruction fetch and data access. It sits between the datapath (PC, ALU result, register read data), the control unit and the single RAM port. It fetches an instruction and holds it stable for decode, then runs the data access if the control unit requests one. It pulses `pc_en` once per retired instruction and parks the core on halt.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: wait-cycle limit per memory access; used only with `TIMEOUT_EN`. Legal range 1..255, 8-bit counter.

Ports:
- `CLK` in 1: clock, rising edge.
- `RST` in 1: reset, asynchronous, active-high.
- `iaddr` in 32: PC value to fetch from.
- `daddr` in 32: data address (ALU result).
- `dstore` in 32: store data (rt read value).
- `MemRead` in 1: from the control unit; the current instruction is a load.
- `MemWr` in 1: from the control unit; the current instruction is a store.
- `halt` in 1: from the control unit; the current instruction is halt.
- `ramready` in 1: the RAM has completed the access in this cycle.
- `ramload` in 32: RAM read data, valid when `ramready`=1.
- `ramaddr` out 32: RAM address.
- `ramstore` out 32: RAM write data.
- `ramREN` out 1: RAM read strobe.
- `ramWEN` out 1: RAM write strobe.
- `instruction` out 32: latched instruction, drives the control unit.
- `dload` out 32: latched load data.
- `pc_en` out 1: one-cycle retire pulse.
- `halted` out 1: sticky halt flag.
- `timeout` out 1: sticky timeout flag.

## Operation
- States: IDLE, FETCH, EXEC, DATA, HALT.
- Reset:
  - State goes to IDLE.
  - `instruction`, `dload`, `halted` and `timeout` go to 0.
  - All strobes, `pc_en`, `ramaddr` and `ramstore` are 0 while `RST`=1. They are decoded from state, so they drop immediately on `RST` even mid-access.
- IDLE: no strobes. Goes to FETCH next cycle.
- FETCH: `ramREN`=1, `ramaddr`=`iaddr`. When `ramready`=1, latch `ramload` into `instruction` and go to EXEC.
- EXEC: no strobes; the control unit decodes the latched `instruction`. Exits are checked in this order:
  - `halt`=1: go to HALT. No `pc_en`.
  - `MemWr`=1 or `MemRead`=1: go to DATA.
  - Otherwise: `pc_en`=1 and go to FETCH.
- DATA: `ramaddr`=`daddr`.
  - If `MemWr`=1: `ramWEN`=1, `ramstore`=`dstore`, `ramREN`=0. Write wins when both `MemWr` and `MemRead` are set.
  - Else: `ramREN`=1.
  - On `ramready`=1: latch `ramload` into `dload` (reads only), assert `pc_en`=1, go to FETCH.
- HALT: `halted`=1, no strobes, no `pc_en`. Only `RST` leaves this state.
- `ramaddr`/`ramstore` are 0 whenever the corresponding strobe is 0.
- Integration rule: the datapath qualifies register-file writes and the PC update with `pc_en`, so each instruction commits exactly once.

## Timing
- `pc_en`, the strobes and `ramaddr` are combinational from the state and current inputs. Latches (`instruction`, `dload`) update on the `CLK` edge that ends the `ramready` cycle.
- Minimum latency with zero wait states (`ramready` high in the request cycle):
  - Non-memory instruction: 2 cycles (FETCH, EXEC).
  - Load/store: 3 cycles (FETCH, EXEC, DATA).
- Each wait cycle (`ramready`=0) adds one cycle in FETCH or DATA. Address and strobes stay stable throughout.
- `pc_en` is high for exactly one cycle per retired instruction and is never high in two consecutive cycles.
- `ramready` is ignored in IDLE, EXEC and HALT.
- First fetch request appears 1 cycle after `RST` falls (IDLE occupies that cycle).

## Configuration
- `TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entry to FETCH or DATA.
  - It increments on each cycle in those states with `ramready`=0.
  - When the counter reaches `TIMEOUT_CYCLES`, set `timeout`=1 and `halted`=1 and go to HALT on the next edge. No latch update and no `pc_en` occur.
- `TIMEOUT_EN` undefined:
  - No counter. Accesses wait indefinitely.
  - The `timeout` port stays present, tied to 0.

## Test plan
- Reset:
  - Hold `RST`=1 and confirm all outputs are 0.
  - Release, then confirm one cycle with no strobes, followed by `ramREN`=1 with `ramaddr`=`iaddr`=0x0000_0000.
  - Reassert `RST` mid-DATA and confirm the strobes drop in the same cycle.
- ALU instruction, zero wait:
  - Stimulus: `ramready`=1, `ramload`=0x0022_1820, no `MemRead`/`MemWr`.
  - Required: `instruction`=0x0022_1820 after FETCH, `pc_en` pulses every 2nd cycle.
- Load with 3 wait states:
  - Stimulus: `daddr`=0x0000_0100, `ramready` low for 3 cycles in DATA, then high with `ramload`=0xDEAD_BEEF.
  - Required: `ramREN`=1 and `ramaddr`=0x100 held for 4 cycles, then `dload`=0xDEAD_BEEF and a single `pc_en` in the ready cycle.
- Store:
  - Stimulus: `MemWr`=1, `dstore`=0x1234_5678, `daddr`=0x0000_0200.
  - Required in DATA: `ramWEN`=1, `ramREN`=0, `ramstore`=0x1234_5678, `ramaddr`=0x200.
  - With `MemRead`=`MemWr`=1, still a write.
- Halt:
  - Stimulus: `halt`=1 in EXEC.
  - Required: `halted`=1 next cycle, no `pc_en`, no strobes for 50 cycles, cleared only by `RST`.
- Timeout, with `TIMEOUT_CYCLES`=4 and `ramready` held 0 in FETCH:
  - With `TIMEOUT_EN`: `timeout`=1 and `halted`=1 after 4 wait cycles.
  - Without `TIMEOUT_EN`: still in FETCH with `ramREN`=1 after 100 cycles, `timeout`=0.

Source files
------------

// File: rtl/mem_access_sequencer.sv
// rtl/mem_access_sequencer.sv - shared RAM port sequencer for instruction fetch and data access
// Optional wait-state watchdog enabled by defining TIMEOUT_EN.
module mem_access_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] iaddr,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  input  logic        MemRead,
  input  logic        MemWr,
  input  logic        halt,
  input  logic        ramready,
  input  logic [31:0] ramload,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] instruction,
  output logic [31:0] dload,
  output logic        pc_en,
  output logic        halted,
  output logic        timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0] state;
  logic [2:0] next_state;
  logic       wait_expired;

`ifdef TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] wait_cnt;
  logic       waiting;

  assign waiting      = ((state == S_FETCH) || (state == S_DATA)) && !ramready;
  assign wait_expired = waiting && ((wait_cnt + 8'd1) == TIMEOUT_LIMIT);

  // Any completed access or state change leaves the counter at zero, so it
  // is already clear on every entry to FETCH or DATA.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wait_cnt <= 8'd0;
      timeout  <= 1'b0;
    end else begin
      wait_cnt <= waiting ? wait_cnt + 8'd1 : 8'd0;
      if (wait_expired)
        timeout <= 1'b1;
    end
  end
`else
  assign wait_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  // Strobes and address are decoded from state so reset drops them at once.
  always_comb begin
    next_state = state;
    ramaddr    = 32'd0;
    ramstore   = 32'd0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    pc_en      = 1'b0;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        if (ramready)
          next_state = S_EXEC;
        else if (wait_expired)
          next_state = S_HALT;
      end
      S_EXEC: begin
        if (halt)
          next_state = S_HALT;
        else if (MemWr || MemRead)
          next_state = S_DATA;
        else begin
          pc_en      = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_DATA: begin
        ramaddr = daddr;
        if (MemWr) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = 1'b1;
        end
        if (ramready) begin
          pc_en      = 1'b1;
          next_state = S_FETCH;
        end else if (wait_expired) begin
          next_state = S_HALT;
        end
      end
      S_HALT:  next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= S_IDLE;
      instruction <= 32'd0;
      dload       <= 32'd0;
      halted      <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == S_FETCH) && ramready)
        instruction <= ramload;
      if ((state == S_DATA) && ramready && !MemWr)
        dload <= ramload;
      if (next_state == S_HALT)
        halted <= 1'b1;
    end
  end

endmodule
